// File: rtl/notgate_rr_arbiter_if.sv
// Handshake bundle between NREQ requesters, the shared inverter arbiter and
// the single downstream result consumer.
interface notgate_rr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic [WIDTH-1:0]      resp_data;
  logic [IDW-1:0]        resp_id;
  logic                  resp_ready;
  logic [15:0]           txn_count;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, txn_count
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, txn_count
  );
endinterface

// File: rtl/notgate_rr_arbiter.sv
// Round-robin arbiter sharing one bitwise-NOT datapath among NREQ requesters,
// with a registered single-entry result stage that honours backpressure.
module notgate_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input logic                clk,
  input logic                rst,
  notgate_rr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_reg;
  logic [IDW-1:0]    rr_ptr_reg;
  logic              resp_valid_reg;
  logic [WIDTH-1:0]  resp_data_reg;
  logic [IDW-1:0]    resp_id_reg;
  logic [15:0]       txn_count_reg;

  logic [WIDTH-1:0]  data_arr [NREQ];
  logic [NREQ-1:0]   grant_onehot;
  logic [IDW-1:0]    grant_idx;
  logic              grant_found;
  logic [IDW:0]      scan_idx;
  logic              can_accept;
  logic              accept;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign data_arr[gi]     = bus.req_data[gi*WIDTH +: WIDTH];
      assign grant_onehot[gi] = grant_found && (grant_idx == IDW'(gi));
    end
  endgenerate

  // Scan starts at rr_ptr; the extra index bit keeps the modulo exact for
  // non-power-of-2 NREQ so the grant never lands past NREQ-1.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ))
        scan_idx = scan_idx - (IDW+1)'(NREQ);
      if (!grant_found && bus.req_valid[scan_idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[IDW-1:0];
      end
    end
  end

  assign can_accept    = !rst && ((state_reg == IDLE) || bus.resp_ready);
  assign bus.req_ready = can_accept ? grant_onehot : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      resp_id_reg    <= '0;
      txn_count_reg  <= '0;
    end else begin
      // A new accept overwrites the slot even while BUSY, since accepting
      // while BUSY implies the current result leaves on this same edge.
      if (accept) begin
        resp_data_reg  <= ~data_arr[grant_idx];
        resp_id_reg    <= grant_idx;
        resp_valid_reg <= 1'b1;
        state_reg      <= BUSY;
        rr_ptr_reg     <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end else if (state_reg == BUSY && bus.resp_ready) begin
        resp_valid_reg <= 1'b0;
        state_reg      <= IDLE;
      end
      if (resp_valid_reg && bus.resp_ready)
        txn_count_reg <= txn_count_reg + 16'd1;
    end
  end

  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_data  = resp_data_reg;
  assign bus.resp_id    = resp_id_reg;
  assign bus.txn_count  = txn_count_reg;
endmodule
